// File: rtl/lsu_mem_adapter.sv
// Load/store adapter in front of the 64-bit doubleword data memory.
// It handles byte/half/word/dword loads with extension, and stores sub-dword data by read-modify-write.
module lsu_mem_adapter #(
    parameter int BIG_ENDIAN = 1
) (
    input  logic        p_clk,
    input  logic        p_reset,
    input  logic        p_req,
    output logic        p_ready,
    input  logic        p_isStore,
    input  logic [1:0]  p_size,
    input  logic        p_signed,
    input  logic [63:0] p_addr,
    input  logic [63:0] p_storeData,
    output logic [63:0] p_loadData,
    output logic        p_done,
    output logic        p_misaligned,
    output logic        p_memReadRequest,
    output logic        p_memWriteRequest,
    output logic [63:0] p_memAddress,
    output logic [63:0] p_memWriteData,
    input  logic [63:0] p_memReadData,
    input  logic        p_memWait
);

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    state_t      state_reg, state_next;
    logic        is_store_reg, is_store_next;
    logic [1:0]  size_reg, size_next;
    logic        signed_reg, signed_next;
    logic [63:0] addr_reg, addr_next;
    logic [63:0] store_data_reg, store_data_next;
    logic [63:0] load_data_reg, load_data_next;
    logic        done_reg, done_next;
    logic        misaligned_reg, misaligned_next;
    logic        rd_req_reg, rd_req_next;
    logic        wr_req_reg, wr_req_next;
    logic [63:0] mem_addr_reg, mem_addr_next;
    logic [63:0] wr_data_reg, wr_data_next;

    logic        req_misaligned;
    logic [2:0]  byte_off;
    logic [3:0]  lane_bytes;
    logic [2:0]  byte_shift;
    logic [5:0]  bit_shift;
    logic [63:0] size_mask;
    logic [63:0] lane_raw;
    logic [63:0] lane_ext;
    logic [63:0] lane_mask;
    logic [63:0] lane_data;
    logic [63:0] merged_data;

    function automatic logic [63:0] mask_for_size(input logic [1:0] size);
        case (size)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] extend_lane(input logic [63:0] raw, input logic [1:0] size,
                                                input logic sgn);
        case (size)
            2'd0:    return {{56{sgn & raw[7]}}, raw[7:0]};
            2'd1:    return {{48{sgn & raw[15]}}, raw[15:0]};
            2'd2:    return {{32{sgn & raw[31]}}, raw[31:0]};
            default: return raw;
        endcase
    endfunction

    always_comb begin
        req_misaligned = 1'b0;
        case (p_size)
            2'd1:    req_misaligned = p_addr[0];
            2'd2:    req_misaligned = |p_addr[1:0];
            2'd3:    req_misaligned = |p_addr[2:0];
            default: req_misaligned = 1'b0;
        endcase
    end

    // Lane position is expressed as a right shift of the doubleword down to bit 0.
    assign byte_off   = addr_reg[2:0];
    assign lane_bytes = 4'd1 << size_reg;
    assign byte_shift = (BIG_ENDIAN != 0) ? 3'(4'd8 - {1'b0, byte_off} - lane_bytes) : byte_off;
    assign bit_shift  = {byte_shift, 3'b000};
    assign size_mask  = mask_for_size(size_reg);

    assign lane_raw  = p_memReadData >> bit_shift;
    assign lane_ext  = extend_lane(lane_raw, size_reg, signed_reg);
    assign lane_mask = size_mask << bit_shift;
    assign lane_data = (store_data_reg & size_mask) << bit_shift;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_merge
            assign merged_data[8*gi +: 8] = lane_mask[8*gi] ? lane_data[8*gi +: 8]
                                                            : p_memReadData[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        is_store_next   = is_store_reg;
        size_next       = size_reg;
        signed_next     = signed_reg;
        addr_next       = addr_reg;
        store_data_next = store_data_reg;
        load_data_next  = load_data_reg;
        mem_addr_next   = mem_addr_reg;
        wr_data_next    = wr_data_reg;
        done_next       = 1'b0;
        misaligned_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (p_req) begin
                    is_store_next   = p_isStore;
                    size_next       = p_size;
                    signed_next     = p_signed;
                    addr_next       = p_addr;
                    store_data_next = p_storeData;
                    if (req_misaligned) begin
                        done_next       = 1'b1;
                        misaligned_next = 1'b1;
                    end else begin
                        mem_addr_next = {3'b000, p_addr[63:3]};
                        if (p_isStore && (p_size == 2'd3)) begin
                            wr_data_next = p_storeData;
                            state_next   = WR;
                        end else begin
                            state_next = RD;
                        end
                    end
                end
            end
            RD: begin
                if (!p_memWait) begin
                    state_next = CAP;
                end
            end
            CAP: begin
                if (is_store_reg) begin
                    wr_data_next = merged_data;
                    state_next   = WR;
                end else begin
                    load_data_next = lane_ext;
                    done_next      = 1'b1;
                    state_next     = IDLE;
                end
            end
            WR: begin
                if (!p_memWait) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Requests are registered off the next state so they are glitch-free and mutually exclusive.
        rd_req_next = (state_next == RD);
        wr_req_next = (state_next == WR);
    end

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state_reg      <= IDLE;
            is_store_reg   <= 1'b0;
            size_reg       <= 2'd0;
            signed_reg     <= 1'b0;
            addr_reg       <= 64'd0;
            store_data_reg <= 64'd0;
            load_data_reg  <= 64'd0;
            done_reg       <= 1'b0;
            misaligned_reg <= 1'b0;
            rd_req_reg     <= 1'b0;
            wr_req_reg     <= 1'b0;
            mem_addr_reg   <= 64'd0;
            wr_data_reg    <= 64'd0;
        end else begin
            state_reg      <= state_next;
            is_store_reg   <= is_store_next;
            size_reg       <= size_next;
            signed_reg     <= signed_next;
            addr_reg       <= addr_next;
            store_data_reg <= store_data_next;
            load_data_reg  <= load_data_next;
            done_reg       <= done_next;
            misaligned_reg <= misaligned_next;
            rd_req_reg     <= rd_req_next;
            wr_req_reg     <= wr_req_next;
            mem_addr_reg   <= mem_addr_next;
            wr_data_reg    <= wr_data_next;
        end
    end

    assign p_ready           = (state_reg == IDLE);
    assign p_loadData        = load_data_reg;
    assign p_done            = done_reg;
    assign p_misaligned      = misaligned_reg;
    assign p_memReadRequest  = rd_req_reg;
    assign p_memWriteRequest = wr_req_reg;
    assign p_memAddress      = mem_addr_reg;
    assign p_memWriteData    = wr_data_reg;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed bench for lsu_mem_adapter with a small doubleword memory model behind it.
module tb_lsu_mem_adapter;

    logic        p_clk = 1'b0;
    logic        p_reset;
    logic        p_req;
    logic        p_ready;
    logic        p_isStore;
    logic [1:0]  p_size;
    logic        p_signed;
    logic [63:0] p_addr;
    logic [63:0] p_storeData;
    logic [63:0] p_loadData;
    logic        p_done;
    logic        p_misaligned;
    logic        p_memReadRequest;
    logic        p_memWriteRequest;
    logic [63:0] p_memAddress;
    logic [63:0] p_memWriteData;
    logic [63:0] p_memReadData;
    logic        p_memWait;

    int errors = 0;
    int checks = 0;

    logic [63:0] mem [0:7];
    int          n_rd = 0;
    int          n_wr = 0;
    logic [63:0] last_rd_addr = 64'd0;
    logic [63:0] last_wr_addr = 64'd0;
    int          addr_bad = 0;
    int          both_bad = 0;

    lsu_mem_adapter #(.BIG_ENDIAN(1)) dut (
        .p_clk            (p_clk),
        .p_reset          (p_reset),
        .p_req            (p_req),
        .p_ready          (p_ready),
        .p_isStore        (p_isStore),
        .p_size           (p_size),
        .p_signed         (p_signed),
        .p_addr           (p_addr),
        .p_storeData      (p_storeData),
        .p_loadData       (p_loadData),
        .p_done           (p_done),
        .p_misaligned     (p_misaligned),
        .p_memReadRequest (p_memReadRequest),
        .p_memWriteRequest(p_memWriteRequest),
        .p_memAddress     (p_memAddress),
        .p_memWriteData   (p_memWriteData),
        .p_memReadData    (p_memReadData),
        .p_memWait        (p_memWait)
    );

    always #5 p_clk = ~p_clk;

    // Memory: registers read data on the edge that samples an unstalled read; loads contents during reset.
    always @(posedge p_clk) begin
        if (p_reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= 64'd0;
            mem[2] <= 64'h0123_4567_89AB_CDEF;
            p_memReadData <= 64'd0;
        end else if (!p_memWait) begin
            if (p_memReadRequest) begin
                p_memReadData <= mem[p_memAddress[2:0]];
                last_rd_addr  <= p_memAddress;
                n_rd          <= n_rd + 1;
            end
            if (p_memWriteRequest) begin
                mem[p_memAddress[2:0]] <= p_memWriteData;
                last_wr_addr           <= p_memAddress;
                n_wr                   <= n_wr + 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%016h", tag, got);
        end
    endtask

    // Starts at a sample point, issues one request and returns at the sample point of the done cycle.
    task automatic run_op(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [63:0] a, input logic [63:0] d, input int wait_n,
                          output int done_cyc, output int rd_cyc, output logic mis);
        int c;
        done_cyc    = -1;
        rd_cyc      = 0;
        mis         = 1'b0;
        p_req       = 1'b1;
        p_isStore   = st;
        p_size      = sz;
        p_signed    = sg;
        p_addr      = a;
        p_storeData = d;
        p_memWait   = 1'b0;
        if (!p_ready) begin
            errors++;
            checks++;
            $display("FAIL ready_at_accept: got 0 expected 1");
        end
        @(posedge p_clk); #1;
        p_req       = 1'b0;
        p_addr      = 64'hFFFF_FFFF_FFFF_FFFF;
        p_storeData = 64'h0;
        p_size      = ~sz;
        for (c = 1; c < 30; c++) begin
            if (p_memReadRequest) begin
                rd_cyc++;
                if (p_memAddress !== {3'b000, a[63:3]}) addr_bad++;
            end
            if (p_memWriteRequest && p_memAddress !== {3'b000, a[63:3]}) addr_bad++;
            if (p_memReadRequest && p_memWriteRequest) both_bad++;
            if (p_done) begin
                done_cyc  = c;
                mis       = p_misaligned;
                p_memWait = 1'b0;
                break;
            end
            p_memWait = (c <= wait_n);
            @(posedge p_clk); #1;
        end
        p_memWait = 1'b0;
        $display("op st=%0d sz=%0d sg=%0d addr=0x%0h data=0x%0h -> done_cycle=%0d load=0x%016h mis=%0d",
                 st, sz, sg, a, d, done_cyc, p_loadData, mis);
    endtask

    int   dc, rc, r0, w0, quiet;
    logic mis;

    initial begin
        p_reset = 1'b1; p_req = 1'b0; p_isStore = 1'b0; p_size = 2'd0; p_signed = 1'b0;
        p_addr = 64'd0; p_storeData = 64'd0; p_memWait = 1'b0;
        repeat (3) @(posedge p_clk);
        #1;
        p_reset = 1'b0;

        check_val("rst_ready", 64'(p_ready), 64'd1);
        check_val("rst_done", 64'(p_done), 64'd0);
        check_val("rst_mis", 64'(p_misaligned), 64'd0);
        check_val("rst_rdreq", 64'(p_memReadRequest), 64'd0);
        check_val("rst_wrreq", 64'(p_memWriteRequest), 64'd0);
        check_val("rst_load", p_loadData, 64'd0);
        check_val("rst_maddr", p_memAddress, 64'd0);
        check_val("rst_wdata", p_memWriteData, 64'd0);

        r0 = n_rd; w0 = n_wr;
        run_op(1'b0, 2'd0, 1'b1, 64'h17, 64'd0, 0, dc, rc, mis);
        check_val("lb_data", p_loadData, 64'hFFFF_FFFF_FFFF_FFEF);
        check_val("lb_cycle", 64'(dc), 64'd3);
        check_val("lb_reads", 64'(n_rd - r0), 64'd1);
        check_val("lb_writes", 64'(n_wr - w0), 64'd0);
        check_val("lb_raddr", last_rd_addr, 64'd2);

        run_op(1'b0, 2'd1, 1'b0, 64'h12, 64'd0, 0, dc, rc, mis);
        check_val("lhu_data", p_loadData, 64'h0000_0000_0000_4567);
        check_val("lhu_cycle", 64'(dc), 64'd3);

        run_op(1'b0, 2'd2, 1'b1, 64'h10, 64'd0, 0, dc, rc, mis);
        check_val("lw_data", p_loadData, 64'h0000_0000_0123_4567);

        r0 = n_rd; w0 = n_wr;
        run_op(1'b1, 2'd2, 1'b0, 64'h14, 64'h0000_0000_DEAD_BEEF, 0, dc, rc, mis);
        check_val("sw_cycle", 64'(dc), 64'd4);
        check_val("sw_mem", mem[2], 64'h0123_4567_DEAD_BEEF);
        check_val("sw_reads", 64'(n_rd - r0), 64'd1);
        check_val("sw_writes", 64'(n_wr - w0), 64'd1);
        check_val("sw_waddr", last_wr_addr, 64'd2);

        r0 = n_rd; w0 = n_wr;
        run_op(1'b1, 2'd3, 1'b0, 64'h18, 64'h1122_3344_5566_7788, 0, dc, rc, mis);
        check_val("sd_cycle", 64'(dc), 64'd2);
        check_val("sd_reads", 64'(n_rd - r0), 64'd0);
        check_val("sd_writes", 64'(n_wr - w0), 64'd1);
        check_val("sd_mem", mem[3], 64'h1122_3344_5566_7788);

        // Issued in the SD done cycle: exercises back-to-back acceptance.
        check_val("b2b_ready", 64'(p_ready), 64'd1);
        run_op(1'b0, 2'd3, 1'b0, 64'h18, 64'd0, 0, dc, rc, mis);
        check_val("ld_data", p_loadData, 64'h1122_3344_5566_7788);
        check_val("ld_cycle", 64'(dc), 64'd3);

        r0 = n_rd; w0 = n_wr;
        run_op(1'b0, 2'd2, 1'b1, 64'h12, 64'd0, 0, dc, rc, mis);
        check_val("mis_cycle", 64'(dc), 64'd1);
        check_val("mis_flag", 64'(mis), 64'd1);
        check_val("mis_rdcyc", 64'(rc), 64'd0);
        check_val("mis_reads", 64'(n_rd - r0), 64'd0);
        check_val("mis_writes", 64'(n_wr - w0), 64'd0);
        check_val("mis_load", p_loadData, 64'h1122_3344_5566_7788);

        run_op(1'b0, 2'd1, 1'b1, 64'h16, 64'd0, 0, dc, rc, mis);
        check_val("lh_neg", p_loadData, 64'hFFFF_FFFF_FFFF_BEEF);
        check_val("lh_mis", 64'(mis), 64'd0);

        run_op(1'b0, 2'd2, 1'b0, 64'h14, 64'd0, 0, dc, rc, mis);
        check_val("lwu_data", p_loadData, 64'h0000_0000_DEAD_BEEF);

        run_op(1'b1, 2'd0, 1'b0, 64'h11, 64'h1234_5678_9ABC_DEAA, 0, dc, rc, mis);
        check_val("sb_cycle", 64'(dc), 64'd4);
        check_val("sb_mem", mem[2], 64'h01AA_4567_DEAD_BEEF);

        r0 = n_rd;
        run_op(1'b0, 2'd0, 1'b1, 64'h14, 64'd0, 3, dc, rc, mis);
        check_val("wait_data", p_loadData, 64'hFFFF_FFFF_FFFF_FFDE);
        check_val("wait_cycle", 64'(dc), 64'd6);
        check_val("wait_rdcyc", 64'(rc), 64'd4);
        check_val("wait_reads", 64'(n_rd - r0), 64'd1);

        run_op(1'b0, 2'd0, 1'b0, 64'h11, 64'd0, 0, dc, rc, mis);
        check_val("lbu_data", p_loadData, 64'h0000_0000_0000_00AA);

        check_val("addr_stable", 64'(addr_bad), 64'd0);
        check_val("rd_wr_excl", 64'(both_bad), 64'd0);

        // Reset while an SH sits in WR: request must drop and no completion may follow.
        p_req = 1'b1; p_isStore = 1'b1; p_size = 2'd1; p_signed = 1'b0;
        p_addr = 64'h08; p_storeData = 64'h0000_0000_0000_CAFE; p_memWait = 1'b0;
        @(posedge p_clk); #1;
        p_req = 1'b0;
        @(posedge p_clk); #1;
        @(posedge p_clk); #1;
        check_val("sh_in_wr", 64'(p_memWriteRequest), 64'd1);
        p_reset = 1'b1; p_memWait = 1'b1;
        @(posedge p_clk); #1;
        p_reset = 1'b0; p_memWait = 1'b0;
        check_val("rst_wr_drop", 64'(p_memWriteRequest), 64'd0);
        check_val("rst_rd_low", 64'(p_memReadRequest), 64'd0);
        check_val("rst_ready2", 64'(p_ready), 64'd1);
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            if (p_done || p_memWriteRequest) quiet++;
            @(posedge p_clk); #1;
        end
        check_val("rst_no_done", 64'(quiet), 64'd0);
        check_val("rst_mem1", mem[1], 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
